// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    // Register-address fields live beside this struct so their width can follow RA_W.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } shadow_ctl_t;

endpackage

// File: rtl/hazard_shadow_slot.sv
// One shadow pipeline slot: loads the upstream stage, holds on freeze, loads a bubble on clear.
module hazard_shadow_slot
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            clear,
    input  shadow_ctl_t     d_ctl,
    input  logic [RA_W-1:0] d_rs1,
    input  logic [RA_W-1:0] d_rs2,
    input  logic [RA_W-1:0] d_rd,
    output shadow_ctl_t     q_ctl,
    output logic [RA_W-1:0] q_rs1,
    output logic [RA_W-1:0] q_rs2,
    output logic [RA_W-1:0] q_rd
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_ctl <= '0;
            q_rs1 <= '0;
            q_rs2 <= '0;
            q_rd  <= '0;
        end else if (!hold) begin
            if (clear) begin
                q_ctl <= '0;
                q_rs1 <= '0;
                q_rs2 <= '0;
                q_rd  <= '0;
            end else begin
                q_ctl <= d_ctl;
                q_rs1 <= d_rs1;
                q_rs2 <= d_rs2;
                q_rd  <= d_rd;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow scoreboard of EX/MEM/WB,
// EX forward selects, load-use stall, memory-wait freeze, branch flush and event counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W         = 5,
    parameter int unsigned BRANCH_STAGE = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_stall,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic BR_IN_MEM = (BRANCH_STAGE == STG_MEM);

    shadow_ctl_t     id_ctl, ex_ctl, mem_ctl, wb_ctl;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [RA_W-1:0] mem_rs1, mem_rs2, mem_rd;
    logic [RA_W-1:0] wb_rs1, wb_rs2, wb_rd;
    logic            load_use, br_act, lu_act;
    logic            mem_fwd_ok, wb_fwd_ok;
    logic            unused_fields;

    assign id_ctl = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read};

    hazard_shadow_slot #(.RA_W(RA_W)) u_ex_slot (
        .clk(clk), .reset(reset), .hold(mem_busy), .clear(br_act | lu_act),
        .d_ctl(id_ctl), .d_rs1(id_rs1), .d_rs2(id_rs2), .d_rd(id_rd),
        .q_ctl(ex_ctl), .q_rs1(ex_rs1), .q_rs2(ex_rs2), .q_rd(ex_rd)
    );

    hazard_shadow_slot #(.RA_W(RA_W)) u_mem_slot (
        .clk(clk), .reset(reset), .hold(mem_busy), .clear(br_act & BR_IN_MEM),
        .d_ctl(ex_ctl), .d_rs1(ex_rs1), .d_rs2(ex_rs2), .d_rd(ex_rd),
        .q_ctl(mem_ctl), .q_rs1(mem_rs1), .q_rs2(mem_rs2), .q_rd(mem_rd)
    );

    hazard_shadow_slot #(.RA_W(RA_W)) u_wb_slot (
        .clk(clk), .reset(reset), .hold(mem_busy), .clear(1'b0),
        .d_ctl(mem_ctl), .d_rs1(mem_rs1), .d_rs2(mem_rs2), .d_rd(mem_rd),
        .q_ctl(wb_ctl), .q_rs1(wb_rs1), .q_rs2(wb_rs2), .q_rd(wb_rd)
    );

    assign unused_fields = ^{wb_ctl.mem_read, wb_rs1, wb_rs2};

    // Priority reset > mem_busy > br_taken > load-use folded into the qualifying terms.
    always_comb begin
        load_use = ex_ctl.valid & ex_ctl.mem_read & (ex_rd != '0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        br_act   = br_taken & ~mem_busy & ~reset;
        lu_act   = load_use & ~br_taken & ~mem_busy & ~reset;

        pc_stall     = (mem_busy & ~reset) | lu_act;
        if_id_stall  = (mem_busy & ~reset) | lu_act;
        id_ex_stall  = mem_busy & ~reset;
        ex_mem_stall = mem_busy & ~reset;
        mem_wb_stall = mem_busy & ~reset;
        if_id_flush  = br_act;
        id_ex_flush  = br_act | lu_act;
        ex_mem_flush = br_act & BR_IN_MEM;
    end

    always_comb begin
        mem_fwd_ok = mem_ctl.valid & mem_ctl.reg_write & (mem_rd != '0);
        wb_fwd_ok  = wb_ctl.valid & wb_ctl.reg_write & (wb_rd != '0);

        forward_a = FWD_IDEX;
        if (mem_fwd_ok && (mem_rd == ex_rs1))     forward_a = FWD_EXMEM;
        else if (wb_fwd_ok && (wb_rd == ex_rs1))  forward_a = FWD_MEMWB;

        forward_b = FWD_IDEX;
        if (mem_fwd_ok && (mem_rd == ex_rs2))     forward_b = FWD_EXMEM;
        else if (wb_fwd_ok && (wb_rd == ex_rs2))  forward_b = FWD_MEMWB;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_act && (flush_cnt != '1))   flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (default, BRANCH_STAGE=2, CNT_W=2) share stimulus.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BUSY = 8'b1101_0101;
    localparam logic [7:0] C_BR3  = 8'b0010_1010;
    localparam logic [7:0] C_BR2  = 8'b0010_1000;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, br_taken, mem_busy;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        pc_stall[3], if_id_stall[3], if_id_flush[3], id_ex_stall[3];
    logic        id_ex_flush[3], ex_mem_stall[3], ex_mem_flush[3], mem_wb_stall[3];
    logic [1:0]  forward_a[3], forward_b[3];
    logic [15:0] stall_cnt[2], flush_cnt[2];
    logic [1:0]  stall_cnt_c, flush_cnt_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_stall(id_ex_stall[0]), .id_ex_flush(id_ex_flush[0]), .ex_mem_stall(ex_mem_stall[0]),
        .ex_mem_flush(ex_mem_flush[0]), .mem_wb_stall(mem_wb_stall[0]),
        .forward_a(forward_a[0]), .forward_b(forward_b[0]),
        .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    pipeline_hazard_ctrl #(.BRANCH_STAGE(2)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_stall(id_ex_stall[1]), .id_ex_flush(id_ex_flush[1]), .ex_mem_stall(ex_mem_stall[1]),
        .ex_mem_flush(ex_mem_flush[1]), .mem_wb_stall(mem_wb_stall[1]),
        .forward_a(forward_a[1]), .forward_b(forward_b[1]),
        .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_stall(pc_stall[2]), .if_id_stall(if_id_stall[2]), .if_id_flush(if_id_flush[2]),
        .id_ex_stall(id_ex_stall[2]), .id_ex_flush(id_ex_flush[2]), .ex_mem_stall(ex_mem_stall[2]),
        .ex_mem_flush(ex_mem_flush[2]), .mem_wb_stall(mem_wb_stall[2]),
        .forward_a(forward_a[2]), .forward_b(forward_b[2]),
        .stall_cnt(stall_cnt_c), .flush_cnt(flush_cnt_c)
    );

    function automatic logic [7:0] ctl(input int i);
        return {pc_stall[i], if_id_stall[i], if_id_flush[i], id_ex_stall[i],
                id_ex_flush[i], ex_mem_stall[i], ex_mem_flush[i], mem_wb_stall[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; br_taken = 0; mem_busy = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic rw, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (ctl(i) !== C_NONE || forward_a[i] !== 2'b00 || forward_b[i] !== 2'b00) begin
                fails++;
                $display("FAIL reset_outputs[%0d] ctl=%b fa=%b fb=%b exp ctl=%b fa=00 fb=00",
                         i, ctl(i), forward_a[i], forward_b[i], C_NONE);
            end
        end
        tests++;
        if (stall_cnt[0] !== 16'd0 || flush_cnt[0] !== 16'd0 || stall_cnt_c !== 2'd0) begin
            fails++;
            $display("FAIL reset_counters stall=%0d flush=%0d stall_c=%0d exp 0 0 0",
                     stall_cnt[0], flush_cnt[0], stall_cnt_c);
        end
    endtask

    task automatic test_forward();
        // back-to-back dependency: EX_MEM forward
        do_reset();
        set_id(5'd1, 5'd2, 5'd5, 1, 1, 1, 0); tick();
        set_id(5'd5, 5'd1, 5'd6, 1, 1, 1, 0); tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b10 || forward_b[0] !== 2'b00) begin
            fails++;
            $display("FAIL fwd_exmem fa=%b fb=%b exp fa=10 fb=00", forward_a[0], forward_b[0]);
        end
        // dependency two apart: MEM_WB forward
        do_reset();
        set_id(5'd1, 5'd2, 5'd5, 1, 1, 1, 0); tick();
        set_id(5'd3, 5'd4, 5'd9, 1, 1, 1, 0); tick();
        set_id(5'd5, 5'd1, 5'd6, 1, 1, 1, 0); tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b01 || forward_b[0] !== 2'b00) begin
            fails++;
            $display("FAIL fwd_memwb fa=%b fb=%b exp fa=01 fb=00", forward_a[0], forward_b[0]);
        end
        // both stages write x5: the younger EX_MEM copy wins
        do_reset();
        set_id(5'd1, 5'd2, 5'd5, 1, 1, 1, 0); tick();
        set_id(5'd3, 5'd4, 5'd5, 1, 1, 1, 0); tick();
        set_id(5'd5, 5'd5, 5'd6, 1, 1, 1, 0); tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b10 || forward_b[0] !== 2'b10) begin
            fails++;
            $display("FAIL fwd_priority fa=%b fb=%b exp fa=10 fb=10", forward_a[0], forward_b[0]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 1); tick();
        set_id(5'd7, 5'd2, 5'd8, 1, 1, 1, 0); #1;
        tests++;
        if (ctl(0) !== C_LU) begin
            fails++;
            $display("FAIL lu_stall ctl=%b exp=%b", ctl(0), C_LU);
        end
        tick(); #1;
        tests++;
        if (ctl(0) !== C_NONE) begin
            fails++;
            $display("FAIL lu_one_cycle ctl=%b exp=%b", ctl(0), C_NONE);
        end
        tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b01 || stall_cnt[0] !== 16'd1) begin
            fails++;
            $display("FAIL lu_after fa=%b stall_cnt=%0d exp fa=01 stall_cnt=1", forward_a[0], stall_cnt[0]);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_id(5'd1, 5'd2, 5'd0, 1, 1, 1, 1); tick();
        set_id(5'd0, 5'd0, 5'd8, 1, 1, 1, 0); #1;
        tests++;
        if (ctl(0) !== C_NONE) begin
            fails++;
            $display("FAIL ld_x0_stall ctl=%b exp=%b", ctl(0), C_NONE);
        end
        tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b00 || stall_cnt[0] !== 16'd0) begin
            fails++;
            $display("FAIL ld_x0_fwd fa=%b stall_cnt=%0d exp fa=00 stall_cnt=0", forward_a[0], stall_cnt[0]);
        end
        do_reset();
        set_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 1); tick();
        set_id(5'd3, 5'd7, 5'd8, 1, 0, 1, 0); #1;
        tests++;
        if (ctl(0) !== C_NONE) begin
            fails++;
            $display("FAIL unused_rs2 ctl=%b exp=%b", ctl(0), C_NONE);
        end
        id_use_rs2 = 1; #1;
        tests++;
        if (ctl(0) !== C_LU) begin
            fails++;
            $display("FAIL used_rs2 ctl=%b exp=%b", ctl(0), C_LU);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(5'd1, 5'd2, 5'd5, 1, 1, 1, 0); tick();
        set_id(5'd5, 5'd1, 5'd6, 1, 1, 1, 0); br_taken = 1; #1;
        tests++;
        if (ctl(0) !== C_BR3 || ctl(1) !== C_BR2) begin
            fails++;
            $display("FAIL br_flush ctl3=%b ctl2=%b exp %b %b", ctl(0), ctl(1), C_BR3, C_BR2);
        end
        tick();
        br_taken = 0; #1;
        tests++;
        if (ctl(0) !== C_NONE || flush_cnt[0] !== 16'd1 || flush_cnt[1] !== 16'd1) begin
            fails++;
            $display("FAIL br_after ctl=%b flush3=%0d flush2=%0d exp ctl=%b 1 1",
                     ctl(0), flush_cnt[0], flush_cnt[1], C_NONE);
        end
        tick();
        idle(); #1;
        tests++;
        if (forward_a[0] !== 2'b00 || forward_a[1] !== 2'b01) begin
            fails++;
            $display("FAIL br_shadow fa3=%b fa2=%b exp 00 01", forward_a[0], forward_a[1]);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        set_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 1); tick();
        set_id(5'd7, 5'd2, 5'd8, 1, 1, 1, 0); br_taken = 1; mem_busy = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (ctl(0) !== C_BUSY) begin
                fails++;
                $display("FAIL busy_freeze[%0d] ctl=%b exp=%b", c, ctl(0), C_BUSY);
            end
            tick();
        end
        mem_busy = 0; br_taken = 0; #1;
        tests++;
        if (ctl(0) !== C_LU) begin
            fails++;
            $display("FAIL busy_shadow_held ctl=%b exp=%b", ctl(0), C_LU);
        end
        br_taken = 1; #1;
        tests++;
        if (ctl(0) !== C_BR3 || stall_cnt[0] !== 16'd3) begin
            fails++;
            $display("FAIL busy_then_branch ctl=%b stall_cnt=%0d exp ctl=%b stall_cnt=3",
                     ctl(0), stall_cnt[0], C_BR3);
        end
        tick();
        idle(); #1;
        tests++;
        if (flush_cnt[0] !== 16'd1 || stall_cnt[0] !== 16'd3) begin
            fails++;
            $display("FAIL busy_counts flush=%0d stall=%0d exp 1 3", flush_cnt[0], stall_cnt[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1;
        for (int c = 0; c < 5; c++) tick();
        mem_busy = 0; #1;
        tests++;
        if (stall_cnt_c !== 2'd3 || stall_cnt[0] !== 16'd5) begin
            fails++;
            $display("FAIL stall_saturate cnt2=%0d cnt16=%0d exp 3 5", stall_cnt_c, stall_cnt[0]);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 1); tick();
        set_id(5'd7, 5'd2, 5'd8, 1, 1, 1, 0); mem_busy = 1; reset = 1;
        tick();
        reset = 0; mem_busy = 0; #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (ctl(i) !== C_NONE || forward_a[i] !== 2'b00) begin
                fails++;
                $display("FAIL reset_mid_stall[%0d] ctl=%b fa=%b exp ctl=%b fa=00", i, ctl(i), forward_a[i], C_NONE);
            end
        end
        tests++;
        if (stall_cnt[0] !== 16'd0 || stall_cnt_c !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_cnt stall=%0d stall_c=%0d exp 0 0", stall_cnt[0], stall_cnt_c);
        end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_busy();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
